// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Sequencing controller for a WIDTH-bit SIPO-with-enable shift register.
// A frame request in IDLE starts a frame. The SIPO enable is then gated for
// exactly WIDTH qualified serial bits, and stalls between bits are allowed.
// The parallel SIPO output is captured into a holding register and offered
// downstream on a valid/ready handshake. The SIPO stays a plain datapath.
// This controller never reorders bits.
//
// Optional feature macro: SIPO_CTRL_TIMEOUT_EN
//   Defined   : an 8-bit stall counter aborts a frame after TIMEOUT
//               consecutive stalled cycles in SHIFT and pulses timeout_err.
//   Undefined : SHIFT waits indefinitely and timeout_err is constant 0.
//
// Parameters
//   WIDTH       bits per frame, equal to the SIPO width (2..16)
//   TIMEOUT     stall limit in cycles, timeout build only (2..255)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       frame request, sampled only in IDLE
//   bit_valid   serial source presents a valid bit on the SIPO input
//   sout        parallel output of the SIPO
//   enable      SIPO shift enable (combinational, forced 0 during rst)
//   busy        high in every state except IDLE (registered)
//   word        last captured frame
//   word_valid  word is held and valid
//   word_ready  consumer accepts word
//   timeout_err one-cycle abort pulse
// -----------------------------------------------------------------------------
module sipo_frame_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic [WIDTH-1:0] sout,
  output logic             enable,
  output logic             busy,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             timeout_err
);

  // Reject illegal parameterisations at elaboration time.
  if ((WIDTH < 2) || (WIDTH > 16) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_param_check
    $error("sipo_frame_ctrl: WIDTH must be 2..16 and TIMEOUT must be 2..255");
  end

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_s;
  logic               shift_en_s;
  logic               capture_s;
  logic               release_s;
  logic               stall_hit_s;
  logic               busy_r;
  logic [WIDTH-1:0]   word_r;
  logic               word_valid_r;

  // Next-state, bit counter and per-state strobes.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    shift_en_s = 1'b0;
    capture_s  = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SHIFT;
          bit_cnt_s = CNT_ZERO;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        // The SIPO shifts exactly when a qualified bit is presented here.
        shift_en_s = bit_valid;
        if (bit_valid) begin
          if (bit_cnt_r == LAST_BIT) begin
            // Last bit of the frame: the counter is parked at zero so it
            // never passes WIDTH-1.
            state_s   = CAPTURE;
            bit_cnt_s = CNT_ZERO;
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_ONE;
          end
        end else if (stall_hit_s) begin
          // Stall limit reached: drop the partial frame.
          state_s   = IDLE;
          bit_cnt_s = CNT_ZERO;
        end else begin
          state_s   = SHIFT;
        end
      end
      CAPTURE: begin
        // The SIPO holds the complete frame on sout in this cycle.
        capture_s = 1'b1;
        state_s   = HOLD;
      end
      HOLD: begin
        // A start arriving together with ready is dropped; IDLE samples
        // start again from the following cycle.
        if (word_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = HOLD;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State register, bit counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= CNT_ZERO;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // Holding register: only a capture or a reset changes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      word_r <= sout;
    end else begin
      word_r <= word_r;
    end
  end

  // Valid flag: set on capture, cleared when the consumer takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid_r <= 1'b0;
    end else if (capture_s) begin
      word_valid_r <= 1'b1;
    end else if (release_s) begin
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= word_valid_r;
    end
  end

`ifdef SIPO_CTRL_TIMEOUT_EN
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  logic [7:0] stall_cnt_r;
  logic       timeout_err_r;

  // The counter holds the number of consecutive stalled cycles already seen,
  // so the TIMEOUT-th stalled cycle is the one that aborts.
  assign stall_hit_s = (state_r == SHIFT) && !bit_valid && (stall_cnt_r == STALL_LAST);

  // Consecutive-stall counter; zero outside SHIFT so every SHIFT entry
  // starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 8'd0;
    end else if ((state_r != SHIFT) || bit_valid || stall_hit_s) begin
      stall_cnt_r <= 8'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + 8'd1;
    end
  end

  // One-cycle abort pulse, registered from the aborting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= stall_hit_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign stall_hit_s = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // enable is combinational so the SIPO shifts on the same edge the bit is
  // qualified; reset overrides it in the cycle it is asserted.
  assign enable     = shift_en_s & ~rst;
  assign busy       = busy_r;
  assign word       = word_r;
  assign word_valid = word_valid_r;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
//
// Self-checking bench for sipo_frame_ctrl (WIDTH=4, TIMEOUT=8). The bench
// contains an MSB-first SIPO driven by the controller's enable. It also keeps a
// frame-level reference model that collects accepted bits in a queue and packs
// them into the expected word. Timeout checks are compiled in when
// SIPO_CTRL_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             bit_valid;
  logic             sin;
  logic [WIDTH-1:0] sipo;
  logic             enable;
  logic             busy;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_ready;
  logic             timeout_err;

  int total = 0;
  int bad   = 0;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_valid  (bit_valid),
    .sout       (sipo),
    .enable     (enable),
    .busy       (busy),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // External SIPO: MSB-first shift, the first bit ends up in the MSB.
  always_ff @(posedge clk) begin
    if (rst) sipo <= '0;
    else if (enable) sipo <= {sipo[WIDTH-2:0], sin};
  end

  // ---------------- reference model (frame level) ----------------
  bit               m_bits[$];
  bit               m_in;
  bit               m_full;
  bit               m_valid;
  bit               m_err;
  logic [WIDTH-1:0] m_word;
  int               m_stall;
  logic             last_en;

  function automatic logic [WIDTH-1:0] pack_bits();
    int w = 0;
    foreach (m_bits[i]) w = (w * 2) + int'(m_bits[i]);
    return WIDTH'(w);
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic bv,
                            input logic si, input logic wr);
    m_err = 1'b0;
    if (r) begin
      m_bits.delete();
      m_in = 0; m_full = 0; m_valid = 0; m_word = '0; m_stall = 0;
    end else if (m_valid) begin
      if (wr) m_valid = 0;
    end else if (m_full) begin
      m_word = pack_bits();
      m_valid = 1; m_full = 0; m_in = 0;
      m_bits.delete();
    end else if (m_in) begin
      if (bv) begin
        m_bits.push_back(si);
        m_stall = 0;
        if (m_bits.size() == WIDTH) m_full = 1;
      end else begin
        m_stall++;
`ifdef SIPO_CTRL_TIMEOUT_EN
        if (m_stall == TIMEOUT) begin
          m_in = 0;
          m_bits.delete();
          m_err = 1;
        end
`endif
      end
    end else if (s) begin
      m_in = 1;
      m_stall = 0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check enable, clock, check registered outputs.
  task automatic cycle(input logic r, input logic s, input logic bv,
                       input logic si, input logic wr);
    rst = r; start = s; bit_valid = bv; sin = si; word_ready = wr;
    #1;
    last_en = enable;
    chk("enable", {15'd0, enable}, {15'd0, (!r && m_in && !m_full && bv)});
    @(posedge clk);
    model_edge(r, s, bv, si, wr);
    #1;
    chk("busy", {15'd0, busy}, {15'd0, (m_in || m_full || m_valid)});
    chk("word_valid", {15'd0, word_valid}, {15'd0, m_valid});
    chk("word", {12'd0, word}, {12'd0, m_word});
    chk("timeout_err", {15'd0, timeout_err}, {15'd0, m_err});
  endtask

  // Complete frame with the given bits (MSB sent first), then release it.
  task automatic run_frame(input logic [WIDTH-1:0] b);
    cycle(0, 1, 0, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) cycle(0, 0, 1, b[i], 0);
    cycle(0, 0, 0, 0, 0);
    chk("frame_word", {12'd0, word}, {12'd0, b});
    cycle(0, 0, 0, 0, 1);
  endtask

  typedef struct {
    logic s, bv, si, rdy;
    logic e_en, e_busy, e_wv;
  } vec_t;

  vec_t tbl[8];
  logic pat[7];
  logic [WIDTH-1:0] saved;
  logic [WIDTH-1:0] sipo_saved;
  int prob;

  initial begin
    // Back-to-back frame 1,0,1,1; start edge is edge 1, word_valid at edge 6.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    m_in = 0; m_full = 0; m_valid = 0; m_err = 0; m_word = '0; m_stall = 0;

    // Reset: two cycles, every output low.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_word", {12'd0, word}, 16'd0);
    chk("rst_wv", {15'd0, word_valid}, 16'd0);
    chk("rst_err", {15'd0, timeout_err}, 16'd0);

    // Reset mid-frame after two bits, with bit_valid still high.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    chk("midrst_enable", {15'd0, last_en}, 16'd0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_word", {12'd0, word}, 16'd0);

    // Table-driven back-to-back frame.
    for (int i = 0; i < 8; i++) begin
      cycle(0, tbl[i].s, tbl[i].bv, tbl[i].si, tbl[i].rdy);
      chk("tbl_enable", {15'd0, last_en}, {15'd0, tbl[i].e_en});
      chk("tbl_busy", {15'd0, busy}, {15'd0, tbl[i].e_busy});
      chk("tbl_wv", {15'd0, word_valid}, {15'd0, tbl[i].e_wv});
    end
    chk("tbl_word", {12'd0, word}, 16'h000b);

    // Stalls: enable mirrors bit_valid, capture follows the 4th valid bit.
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, pat[i], 1'($urandom_range(0, 1)), 0);
      chk("stall_enable", {15'd0, last_en}, {15'd0, pat[i]});
    end
    chk("stall_no_valid_yet", {15'd0, word_valid}, 16'd0);
    cycle(0, 0, 0, 0, 0);
    chk("stall_capture", {15'd0, word_valid}, 16'd1);

    // Handshake: ready low for 5 cycles with stray start and bit_valid.
    saved = word;
    sipo_saved = sipo;
    for (int i = 0; i < 5; i++) begin
      cycle(0, (i == 2), 1, 1, 0);
      chk("hold_word", {12'd0, word}, {12'd0, saved});
      chk("hold_wv", {15'd0, word_valid}, 16'd1);
      chk("hold_sipo", {12'd0, sipo}, {12'd0, sipo_saved});
    end
    cycle(0, 1, 0, 0, 1);
    chk("release_busy", {15'd0, busy}, 16'd0);
    cycle(0, 0, 1, 0, 0);
    chk("idle_enable", {15'd0, last_en}, 16'd0);
    chk("idle_sipo", {12'd0, sipo}, {12'd0, sipo_saved});
    chk("idle_busy", {15'd0, busy}, 16'd0);
    run_frame(4'b0100);

    // Randomized traffic against the reference model.
    prob = 50;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 50) == 0) begin
        case ($urandom_range(0, 2))
          0: prob = 5;
          1: prob = 50;
          default: prob = 95;
        endcase
      end
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < prob),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 40));
    end

`ifdef SIPO_CTRL_TIMEOUT_EN
    // Timeout: 2 bits, then 8 stalled cycles abort and keep the old word.
    cycle(1, 0, 0, 0, 0);
    run_frame(4'b1001);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0, 0, 0);
    chk("to_err", {15'd0, timeout_err}, 16'd1);
    chk("to_busy", {15'd0, busy}, 16'd0);
    chk("to_word", {12'd0, word}, 16'h0009);
    cycle(0, 0, 0, 0, 0);
    chk("to_err_pulse", {15'd0, timeout_err}, 16'd0);

    // A 7-cycle stall does not abort and the frame completes.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0, 0);
    chk("nto_busy", {15'd0, busy}, 16'd1);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("nto_wv", {15'd0, word_valid}, 16'd1);
    chk("nto_word", {12'd0, word}, 16'h0006);
    cycle(0, 0, 0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
